// File: rtl/issue_queue_npicker.sv
// In-order issue queue: one enqueue port, NPICK in-order dequeue lanes, lane k = k-th oldest entry.
// Latency: 1 cycle enqueue-to-issue (0 cycles with IQ_NPICKER_BYPASS_EN when the queue holds < NPICK entries).
// Backpressure: in_ready drops when full or during sys_rst/flush; lanes pop as a leading run of valid&ready.
//
// Ports:
//   sys_clk, sys_rst   clock and synchronous active-high reset
//   flush              synchronous clear of all entries (overrides push and pop)
//   in_valid/in_ready  enqueue handshake, payload in_data
//   out_valid/out_ready per-lane handshake, lane k payload in out_data[k*DATA_W +: DATA_W]
//   count              number of stored entries
// Optional feature macro: IQ_NPICKER_BYPASS_EN (empty-queue bypass onto the first free lane).

module issue_queue_npicker #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int NPICK  = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [NPICK-1:0]        out_valid,
    input  logic [NPICK-1:0]        out_ready,
    output logic [NPICK*DATA_W-1:0] out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;

    logic                    w_push;
    logic [CNT_W-1:0]        w_pops;
    logic                    w_run;
    logic [NPICK-1:0]        w_lane_vld;
    logic [NPICK*DATA_W-1:0] w_lane_dat;

    // Pointer add modulo DEPTH. Both operands are below 2*DEPTH in sum, so one
    // conditional subtract is enough and non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Accept depends only on registered occupancy; a full queue refuses even
    // when lanes are popping this cycle, keeping out_ready off this path.
    assign in_ready = (r_count < CNT_W'(DEPTH)) && !flush && !sys_rst;
    assign w_push   = in_valid && in_ready;

    always_comb begin
        w_lane_vld = '0;
        w_lane_dat = '0;
        for (int k = 0; k < NPICK; k++) begin
            if (r_count > CNT_W'(k)) begin
                w_lane_vld[k] = 1'b1;
                w_lane_dat[k*DATA_W +: DATA_W] = r_mem[ptr_add(r_head, CNT_W'(k))];
            end
`ifdef IQ_NPICKER_BYPASS_EN
            // The first empty lane shows the incoming entry in the same cycle.
            else if (w_push && (r_count == CNT_W'(k))) begin
                w_lane_vld[k] = 1'b1;
                w_lane_dat[k*DATA_W +: DATA_W] = in_data;
            end
`endif
        end
    end

    assign out_valid = w_lane_vld;
    assign out_data  = w_lane_dat;
    assign count     = r_count;

    // Pops form a leading run: a ready lane above a stalled lane is ignored so
    // issue order always equals enqueue order.
    always_comb begin
        w_pops = '0;
        w_run  = 1'b1;
        for (int k = 0; k < NPICK; k++) begin
            if (w_run && w_lane_vld[k] && out_ready[k]) begin
                w_pops = w_pops + CNT_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= ptr_add(r_head, w_pops);
            if (w_push) begin
                r_tail <= (r_tail == PTR_W'(DEPTH-1)) ? '0 : r_tail + PTR_W'(1);
            end
            // With bypass, a consumed incoming entry is counted in both push and pops.
            r_count <= r_count + CNT_W'(w_push) - w_pops;
        end
    end

    // Storage is not reset; w_push is already low during reset and flush.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_issue_queue_npicker.sv
module tb_issue_queue_npicker;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int NPICK  = 3;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready = 3'b000;
    logic [23:0] out_data;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] q[$];

    issue_queue_npicker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NPICK(NPICK)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model: the lanes are simply the oldest entries in order.
    function automatic void model_eval(output logic rdy, output logic [2:0] vld,
                                       output logic [23:0] dat, output int pops,
                                       output logic push);
        logic [7:0] l[$];
        bit run;
        l    = q;
        rdy  = (q.size() < DEPTH) && !flush && !sys_rst;
        push = in_valid && rdy;
`ifdef IQ_NPICKER_BYPASS_EN
        if (push && q.size() < NPICK) l.push_back(in_data);
`endif
        vld  = '0;
        dat  = '0;
        pops = 0;
        run  = 1'b1;
        for (int k = 0; k < NPICK; k++) begin
            if (k < l.size()) begin
                vld[k] = 1'b1;
                dat[k*8 +: 8] = l[k];
            end
        end
        for (int k = 0; k < NPICK; k++) begin
            if (run && vld[k] && out_ready[k]) pops++;
            else run = 1'b0;
        end
    endfunction

    always @(posedge sys_clk) begin
        logic r; logic [2:0] v; logic [23:0] d; int p; logic ps;
        model_eval(r, v, d, p, ps);
        if (sys_rst || flush) begin
            q.delete();
        end else begin
            if (ps) q.push_back(in_data);
            repeat (p) void'(q.pop_front());
        end
    end

    always @(negedge sys_clk) begin
        logic r; logic [2:0] v; logic [23:0] d; int p; logic ps;
        #2;
        if (chk_en) begin
            model_eval(r, v, d, p, ps);
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(r));
            chk("m_out_valid", 32'(out_valid), 32'(v));
            chk("m_out_data", 32'(out_data), 32'(d));
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] r,
                       input logic fl, input logic rs);
        @(negedge sys_clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = fl;
        sys_rst   = rs;
        #3;
    endtask

    initial begin
        cyc(0, 8'h00, 3'b000, 0, 1);
        chk_en = 1'b1;
        cyc(0, 8'h00, 3'b000, 0, 1);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Fill to full with no consumer.
        for (int i = 1; i <= 8; i++) cyc(1, 8'(8'h11 * i), 3'b000, 0, 0);
        cyc(1, 8'h99, 3'b000, 0, 0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_lanes", 32'(out_data), 32'h332211);

        // Drain 3,3,2.
        cyc(0, 8'h00, 3'b111, 0, 0);
        chk("drain1_data", 32'(out_data), 32'h332211);
        cyc(0, 8'h00, 3'b111, 0, 0);
        chk("drain2_data", 32'(out_data), 32'h665544);
        cyc(0, 8'h00, 3'b111, 0, 0);
        chk("drain3_valid", 32'(out_valid), 32'b011);
        chk("drain3_data", 32'(out_data), 32'h008877);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("empty_count", 32'(count), 32'd0);
        chk("empty_valid", 32'(out_valid), 32'd0);

        // Prefix rule.
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 3'b000, 0, 0);
        cyc(0, 8'h00, 3'b101, 0, 0);
        chk("pfx_count4", 32'(count), 32'd4);
        chk("pfx_data", 32'(out_data), 32'hA2A1A0);
        cyc(0, 8'h00, 3'b011, 0, 0);
        chk("pfx_count3", 32'(count), 32'd3);
        chk("pfx_data2", 32'(out_data), 32'hA3A2A1);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("pfx_count1", 32'(count), 32'd1);
        chk("pfx_valid1", 32'(out_valid), 32'b001);
        chk("pfx_data3", 32'(out_data), 32'h0000A3);
        cyc(0, 8'h00, 3'b001, 0, 0);

        // Sustained push/pop across pointer wrap.
        for (int i = 0; i < 20; i++) cyc(1, 8'(8'h30 + i), 3'b001, 0, 0);
        cyc(0, 8'h00, 3'b000, 0, 0);
`ifndef IQ_NPICKER_BYPASS_EN
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_last", 32'(out_data), 32'h000043);
`endif
        cyc(0, 8'h00, 3'b001, 0, 0);

        // Flush with a same-cycle push.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hB0 + i), 3'b000, 0, 0);
        cyc(1, 8'hEE, 3'b111, 1, 0);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_pre_valid", 32'(out_valid), 32'b111);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'hC0 + i), 3'b000, 0, 0);
        cyc(1, 8'hDD, 3'b111, 0, 1);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        cyc(1, 8'h77, 3'b000, 0, 0);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h000077);
        cyc(0, 8'h00, 3'b001, 0, 0);

`ifdef IQ_NPICKER_BYPASS_EN
        // Empty-queue bypass.
        cyc(1, 8'h5A, 3'b001, 0, 0);
        chk("byp_valid", 32'(out_valid), 32'b001);
        chk("byp_data", 32'(out_data), 32'h00005A);
        chk("byp_in_ready", 32'(in_ready), 32'd1);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("byp_count", 32'(count), 32'd0);
        cyc(1, 8'h5B, 3'b000, 0, 0);
        chk("byp_hold_valid", 32'(out_valid), 32'b001);
        cyc(0, 8'h00, 3'b000, 0, 0);
        chk("byp_hold_count", 32'(count), 32'd1);
        cyc(0, 8'h00, 3'b001, 0, 0);
`endif

        cyc(0, 8'h00, 3'b000, 0, 0);
        cyc(0, 8'h00, 3'b000, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue_npicker.md
Name: issue_queue_npicker

Overview:
- Parametrised successor to the two-picker issue queue.
- In-order circular buffer with one enqueue port and NPICK dequeue ("picker") lanes. Lane k always presents the k-th oldest entry.
- Dequeues follow a strict prefix rule, so issue order always equals enqueue order.
- Adds a synchronous flush, an occupancy output, and an optional empty-queue bypass. Sits between decode/rename and the NPICK execution ports.

Parameters:
- DATA_W, 8, payload width in bits.
- DEPTH, 8, number of storage entries; any integer >= NPICK and >= 2 (not required to be a power of two).
- NPICK, 2, number of dequeue lanes; 1..DEPTH.

Ports:
- sys_clk  in  1  clock; all state changes on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  enqueue request.
- in_data  in  DATA_W  enqueue payload.
- in_ready  out  1  enqueue accept.
- out_valid  out  NPICK  bit k: lane k holds a valid entry.
- out_ready  in  NPICK  bit k: consumer accepts lane k.
- out_data  out  NPICK*DATA_W  lane k payload in bits [k*DATA_W +: DATA_W].
- count  out  $clog2(DEPTH+1)  current number of stored entries.

Behaviour:
- Reset: synchronous, active-high. While sys_rst is high at a rising edge, head, tail and count are cleared to 0. Storage contents are not cleared.
- After reset: out_valid = 0, out_data = 0, count = 0, in_ready = 1.
- in_ready is forced to 0 during any cycle in which sys_rst or flush is high.
- State: head pointer, tail pointer, count register.
  - Pointers wrap explicitly from DEPTH-1 to 0.
  - Pointer adds are taken modulo DEPTH.
- in_ready = (count < DEPTH) && !flush && !sys_rst. It is a registered-state function only; there is no combinational path from out_ready.
  - A full queue does not accept an enqueue even if pops occur in the same cycle.
- Lane k outputs:
  - out_valid[k] = (count > k).
  - Lane k data = mem[(head + k) mod DEPTH] when valid, else 0.
- Pop rule:
  - Lane k fires iff out_valid[j] && out_ready[j] for every j <= k.
  - pops = the length of that leading run, 0..NPICK.
  - A ready lane above a non-firing lane is ignored, e.g. ready = 3'b101 with all lanes valid gives pops = 1.
- Push: push = in_valid && in_ready. Data is written at tail, then tail advances by 1.
- Per cycle:
  - head_next = head + pops.
  - count_next = count + push - pops.
  - Simultaneous push and pop are legal at any occupancy below DEPTH.
- Flush: when flush is high at a rising edge, head, tail and count are cleared. Flush overrides push and pop. out_valid still reflects the pre-flush state during the flush cycle, but no handshake completes.
- Latency: an enqueued entry is visible on a lane the cycle after acceptance, or the same cycle when the bypass feature is enabled.
- Boundaries:
  - Empty: all out_valid = 0 and pops = 0.
  - count = DEPTH: in_ready = 0.
  - count < NPICK: upper lanes are invalid and output zero data.
  - Reset mid-operation discards all entries, including any in-flight handshake that cycle.

Optional Feature:
- Macro: IQ_NPICKER_BYPASS_EN.
- Enabled, when count < NPICK and in_valid && in_ready:
  - Lane c (c = count) presents in_data with out_valid[c] = 1 in the same cycle.
  - If lane c fires under the prefix rule, the incoming entry is consumed directly. pops includes it, push still counts, and count_next = count + 1 - pops.
  - Storage write is performed but is immediately popped.
  - in_ready is unchanged, so the bypass is never offered when the queue is full or during flush.
- Disabled: lanes reflect stored entries only, and there is a 1-cycle minimum enqueue-to-issue latency.

Test Plan (DEPTH=8, NPICK=3, DATA_W=8, bypass disabled unless noted):
1. Reset, then enqueue 0x11..0x88 with out_ready=0 -> count reaches 8, in_ready=0 on the 9th cycle, lanes show 0x11/0x22/0x33.
2. Full queue, out_ready=3'b111 for 3 cycles with no enqueue -> pops 3,3,2 in order 0x11..0x88; count reaches 0; all out_valid=0.
3. Prefix rule: 4 entries 0xA0..0xA3, out_ready=3'b101 -> only 0xA0 pops, count=3; next cycle ready=3'b011 -> 0xA1,0xA2 pop, lane0 then shows 0xA3.
4. Wrap: sustain 1 push per cycle and ready=3'b001 for 20 cycles with an incrementing payload -> output order equals input order across pointer wrap, count constant at 1.
5. Flush with 5 entries plus an in_valid push the same cycle -> next cycle count=0, all out_valid=0, pushed value never appears; sys_rst pulse mid-stream gives the same result.
6. IQ_NPICKER_BYPASS_EN, empty queue, in_valid with in_data=0x5A, out_ready=3'b001 -> out_valid[0]=1 and data 0x5A in the same cycle; count stays 0.
